seven_segment_driver: RTL and testbench

- Consumes the registered `digit[31:0]`, `en_digit[7:0]` and `en_dot[7:0]` words from the seven-segment interface stage.
- Time-multiplexes them onto the board's 8-digit common-anode display: one digit lit at a time, with hex-to-segment decode and a blanking gap between digits to suppress ghosting.
- Snapshots its inputs once per full scan frame so the display never tears mid-frame.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/hex_to_seg7.sv | 30 +++
 rtl/seven_segment_driver.sv | 79 +++++++
 tb/tb_seven_segment_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment display blocks: digit count, active-low
// segment codes {g,f,e,d,c,b,a} and the scan state type.
package seg7_pkg;
  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {BLANK, ON} state_t;
endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seven_segment_driver.sv
// 8-digit common-anode scan driver: one digit per slot, blanking gap at the
// start of each slot, inputs snapshotted once per frame to avoid tearing.
module seven_segment_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digit,
  input  logic [7:0]  en_digit,
  input  logic [7:0]  en_dot,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);
  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  state_t        state, state_nxt;
  logic [31:0]   digit_s;
  logic [7:0]    en_digit_s, en_dot_s;
  logic          snap, lit;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;

  always_comb begin
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = idx + IW'(1);
    end
    // state tracks cnt one-for-one, so it is ON exactly when cnt >= BLANK_CYCLES
    state_nxt = (cnt_nxt >= CNT_ON) ? ON : BLANK;
    snap      = (state == BLANK) && (idx == '0) && (cnt == '0);
    lit       = (state == ON) && en_digit_s[idx];
    nib       = digit_s[idx*4 +: 4];
  end

  hex_to_seg7 u_dec (
    .hex (nib),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= BLANK;
      digit_s    <= '0;
      en_digit_s <= '0;
      en_dot_s   <= '0;
      an         <= 8'hFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      state      <= state_nxt;
      frame_tick <= snap;
      if (snap) begin
        digit_s    <= digit;
        en_digit_s <= en_digit;
        en_dot_s   <= en_dot;
      end
      an  <= lit ? ~(8'd1 << idx) : 8'hFF;
      seg <= lit ? seg_dec : SEG_BLANK;
      dp  <= lit ? ~en_dot_s[idx] : 1'b1;
    end
  end
endmodule

// File: tb/tb_seven_segment_driver.sv
// Directed bench for seven_segment_driver with DIGIT_CYCLES=8, BLANK_CYCLES=2.
module tb_seven_segment_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digit = '0;
  logic [7:0]  en_digit = '0;
  logic [7:0]  en_dot = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int pass_cnt = 0;
  int total_cnt = 0;

  seven_segment_driver #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .digit      (digit),
    .en_digit   (en_digit),
    .en_dot     (en_dot),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] code(input logic [3:0] h);
    case (h)
      4'h0: code = 7'b1000000; 4'h1: code = 7'b1111001;
      4'h2: code = 7'b0100100; 4'h3: code = 7'b0110000;
      4'h4: code = 7'b0011001; 4'h5: code = 7'b0010010;
      4'h6: code = 7'b0000010; 4'h7: code = 7'b1111000;
      4'h8: code = 7'b0000000; 4'h9: code = 7'b0010000;
      4'hA: code = 7'b0001000; 4'hB: code = 7'b0000011;
      4'hC: code = 7'b1000110; 4'hD: code = 7'b0100001;
      4'hE: code = 7'b0000110; default: code = 7'b0001110;
    endcase
  endfunction

  // Expected {an,seg,dp} t cycles after a frame_tick: slot t/8 is lit for
  // phases 2..7 when enabled, otherwise everything is dark.
  function automatic logic [15:0] model(input int t, input logic [31:0] d,
                                        input logic [7:0] en, input logic [7:0] dot);
    int s;
    int ph;
    logic [7:0] a;
    s  = (t % 64) / 8;
    ph = t % 8;
    a  = 8'hFF;
    a[s] = 1'b0;
    if (ph >= 2 && en[s]) model = {a, code(d[s*4 +: 4]), ~dot[s]};
    else                  model = {8'hFF, 7'h7F, 1'b1};
  endfunction

  task automatic wait_tick(input string name);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) found = 1;
    end
    total_cnt++;
    if (!found) $display("FAIL %s timeout: frame_tick not seen, required within 200 cycles", name);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    digit = 32'h00000000; en_digit = 8'h01; en_dot = 8'h00; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({an, seg, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_state got %h/%h/%b/%b exp ff/7f/1/0", an, seg, dp, frame_tick);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (frame_tick !== 1'b1) $display("FAIL reset_first_tick got %b exp 1", frame_tick);
    else pass_cnt++;
    for (int t = 0; t < 72; t++) begin
      logic [15:0] e;
      if (t > 0) @(negedge clk);
      e = model(t, 32'h0, 8'h01, 8'h00);
      total_cnt++;
      if ({an, seg, dp} !== e) $display("FAIL reset_scan t=%0d got %h exp %h", t, {an, seg, dp}, e);
      else pass_cnt++;
      total_cnt++;
      if (frame_tick !== (t % 64 == 0)) $display("FAIL reset_tick t=%0d got %b exp %b", t, frame_tick, t % 64 == 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_decode(input logic [31:0] d);
    digit = d; en_digit = 8'hFF; en_dot = 8'h00;
    wait_tick("decode");
    for (int t = 0; t <= 64; t++) begin
      logic [15:0] e;
      if (t > 0) @(negedge clk);
      e = model(t, d, 8'hFF, 8'h00);
      total_cnt++;
      if ({an, seg, dp} !== e) $display("FAIL decode_%h t=%0d got %h exp %h", d, t, {an, seg, dp}, e);
      else pass_cnt++;
      total_cnt++;
      if (frame_tick !== (t % 64 == 0)) $display("FAIL decode_tick t=%0d got %b exp %b", t, frame_tick, t % 64 == 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_fault_pattern();
    digit = 32'hF0000002; en_digit = 8'b10000001; en_dot = 8'h00;
    wait_tick("fault");
    for (int t = 0; t < 64; t++) begin
      logic [15:0] e;
      if (t > 0) @(negedge clk);
      e = model(t, 32'hF0000002, 8'b10000001, 8'h00);
      total_cnt++;
      if ({an, seg, dp} !== e) $display("FAIL fault_pattern t=%0d got %h exp %h", t, {an, seg, dp}, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_snapshot();
    digit = 32'h00000000; en_digit = 8'hFF; en_dot = 8'h00;
    wait_tick("snapshot");
    for (int t = 0; t < 128; t++) begin
      logic [15:0] e;
      if (t > 0) @(negedge clk);
      if (t == 26) digit = 32'h11111111;
      e = model(t, (t < 64) ? 32'h00000000 : 32'h11111111, 8'hFF, 8'h00);
      total_cnt++;
      if ({an, seg, dp} !== e) $display("FAIL snapshot t=%0d got %h exp %h", t, {an, seg, dp}, e);
      else pass_cnt++;
      total_cnt++;
      if (frame_tick !== (t % 64 == 0)) $display("FAIL snapshot_tick t=%0d got %b exp %b", t, frame_tick, t % 64 == 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_dot();
    digit = 32'h89ABCDEF; en_digit = 8'hFF; en_dot = 8'b00001000;
    wait_tick("dot");
    for (int t = 0; t < 64; t++) begin
      if (t > 0) @(negedge clk);
      total_cnt++;
      if (dp !== ~((t / 8 == 3) && (t % 8 >= 2))) $display("FAIL dot t=%0d got %b exp %b", t, dp, ~((t / 8 == 3) && (t % 8 >= 2)));
      else pass_cnt++;
      total_cnt++;
      if ({an, seg, dp} !== model(t, 32'h89ABCDEF, 8'hFF, 8'b00001000))
        $display("FAIL dot_frame t=%0d got %h exp %h", t, {an, seg, dp}, model(t, 32'h89ABCDEF, 8'hFF, 8'b00001000));
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    digit = 32'h76543210; en_digit = 8'hFF; en_dot = 8'h00;
    wait_tick("mid_reset");
    repeat (44) @(negedge clk);
    total_cnt++;
    if (an !== 8'b11011111) $display("FAIL mid_reset_pre got %h exp df", an);
    else pass_cnt++;
    rst = 1'b1;
    digit = 32'hABCDEF01;
    @(negedge clk);
    total_cnt++;
    if ({an, seg, dp, frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL mid_reset_state got %h/%h/%b/%b exp ff/7f/1/0", an, seg, dp, frame_tick);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (frame_tick !== 1'b1) $display("FAIL mid_reset_tick got %b exp 1", frame_tick);
    else pass_cnt++;
    for (int t = 0; t < 64; t++) begin
      logic [15:0] e;
      if (t > 0) @(negedge clk);
      e = model(t, 32'hABCDEF01, 8'hFF, 8'h00);
      total_cnt++;
      if ({an, seg, dp} !== e) $display("FAIL mid_reset_scan t=%0d got %h exp %h", t, {an, seg, dp}, e);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_decode(32'h76543210);
    test_decode(32'hFEDCBA98);
    test_fault_pattern();
    test_snapshot();
    test_dot();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
